serial_add64_ctrl: RTL and testbench

- Multi-cycle sequencer that performs a 64-bit add/subtract by time-multiplexing one 16-bit adder slice over four cycles, least-significant slice first.
- Trades latency for area against the fully unrolled 64-bit ripple adder.
- Sits between a requesting datapath (start/done handshake) and a single SixteenBitAdder instance.
- Latches operands, steps the slice counter, chains the carry through a register, and assembles the result.

---
 rtl/serial_add64_ctrl_pkg.sv | 20 ++
 rtl/serial_add64_ctrl_adder.sv | 19 +
 rtl/serial_add64_ctrl.sv | 108 ++++++++++
 tb/tb_serial_add64_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/serial_add64_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// serial_add64_ctrl_pkg : shared state encoding and slice width for the
//                         slice-serial 64-bit adder/subtractor.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package serial_add64_ctrl_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_add64_ctrl_adder.sv
// ----------------------------------------------------------------------------
// SixteenBitAdder : combinational 16-bit adder slice with carry in/out.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module SixteenBitAdder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {16'd0, c_in};

endmodule

`default_nettype wire

// File: rtl/serial_add64_ctrl.sv
// ----------------------------------------------------------------------------
// serial_add64_ctrl : 64-bit add/subtract built from one 16-bit adder slice
//                     stepped over N_SLICES cycles, least-significant first.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module serial_add64_ctrl
    import serial_add64_ctrl_pkg::*;
#(
    parameter int N_SLICES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        sub,
    input  logic [SLICE_W*N_SLICES-1:0] a,
    input  logic [SLICE_W*N_SLICES-1:0] b,
    input  logic                        c_in,
    output logic [SLICE_W*N_SLICES-1:0] sum,
    output logic                        c_out,
    output logic                        ovf,
    output logic                        busy,
    output logic                        done
);

    localparam int W     = SLICE_W * N_SLICES;
    localparam int IDX_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       op_a;
    logic [W-1:0]       op_b;
    logic               carry;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               accept;
    logic               last;

    // Start is honoured in IDLE and in DONE (back-to-back), never in ADD.
    assign accept = start && (state != ADD);
    assign last   = (state == ADD) && (idx == LAST_IDX);
    assign busy   = (state == ADD);
    assign done   = (state == DONE);

    assign slice_a = op_a[SLICE_W*idx +: SLICE_W];
    assign slice_b = op_b[SLICE_W*idx +: SLICE_W];

    SixteenBitAdder u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry),
        .sum   (slice_sum),
        .c_out (slice_cout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ADD;
            ADD:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? ADD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            idx   <= '0;
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : c_in;
            sum   <= '0;
        end else if (state == ADD) begin
            sum[SLICE_W*idx +: SLICE_W] <= slice_sum;
            carry <= slice_cout;
            idx   <= idx + IDX_W'(1);
            if (last) begin
                c_out <= slice_cout;
                // Overflow uses the already-inverted B for subtraction.
                ovf   <= (op_a[W-1] == op_b[W-1]) && (slice_sum[SLICE_W-1] != op_a[W-1]);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_add64_ctrl.sv
// ----------------------------------------------------------------------------
// tb_serial_add64_ctrl : scoreboard bench for serial_add64_ctrl.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_serial_add64_ctrl;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        v;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        c_in = 1'b0;
    logic [63:0] sum;
    logic        c_out;
    logic        ovf;
    logic        busy;
    logic        done;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_run = 0;
    exp_t q[$];

    serial_add64_ctrl #(.N_SLICES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [63:0] aa, input logic [63:0] bb,
                                   input logic ci, input logic sb);
        exp_t        e;
        logic [64:0] r;
        logic [63:0] ob;
        ob  = sb ? ~bb : bb;
        r   = {1'b0, aa} + {1'b0, ob} + {64'd0, (sb ? 1'b1 : ci)};
        e.s = r[63:0];
        e.c = r[64];
        e.v = (aa[63] == ob[63]) && (r[63] != aa[63]);
        e.t = 0;
        return e;
    endfunction

    // Called at a negedge: drive one request, push its expectation, drop start.
    task automatic issue(input logic [63:0] aa, input logic [63:0] bb, input logic ci,
                         input logic sb, input logic [63:0] es, input logic ec, input logic ev);
        exp_t e;
        start = 1'b1; a = aa; b = bb; c_in = ci; sub = sb;
        e.s = es; e.c = ec; e.v = ev; e.t = cyc + 5;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: compares each done against the oldest expectation.
    always @(negedge clk) begin
        if (busy) begin
            busy_run = busy_run + 1;
        end else if (done) begin
            chk("busy_cycles", 64'(busy_run), 64'd4);
            busy_run = 0;
            if (q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_latency", 64'(cyc), 64'(e.t));
                chk("sum", sum, e.s);
                chk("c_out", 64'(c_out), 64'(e.c));
                chk("ovf", 64'(ovf), 64'(e.v));
            end
        end else begin
            busy_run = 0;
        end
    end

    initial begin
        exp_t m;
        logic [63:0] ra, rb;
        logic        rc, rs;

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outputs", {sum[59:0], c_out, ovf, busy, done}, 64'd0);
            chk("idle_sum_hi", 64'(sum[63:60]), 64'd0);
        end

        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
        drain();
        issue(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        drain();
        issue(64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        drain();
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        drain();
        issue(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0000, 1'b1, 1'b0,
              64'h0000_0000_0001_0000, 1'b0, 1'b0);
        drain();

        // Back-to-back with an ignored start in the middle of ADD.
        issue(64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; a = 64'd100; b = 64'd100; c_in = 1'b0; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("done_before_b2b", 64'(done), 64'd1);
        issue(64'd10, 64'd1, 1'b1, 1'b0, 64'd12, 1'b0, 1'b0);
        drain();

        // Reset two cycles into an operation: abandoned, no done.
        start = 1'b1; a = 64'd1; b = 64'd1; c_in = 1'b0; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("busy_before_reset", 64'(busy), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_sum", sum, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
              64'h2222_2222_2222_2211, 1'b0, 1'b0);
        drain();

        // Random regression issued back-to-back.
        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom);
            rs = 1'($urandom);
            m  = model(ra, rb, rc, rs);
            issue(ra, rb, rc, rs, m.s, m.c, m.v);
            repeat (4) @(negedge clk);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
